simon_core_param: RTL

- Parametrised, iterative Simon block-cipher encryption core covering every standard Simon 2N/MN variant.
- One Feistel round per clock, with on-the-fly key expansion.
- Valid/ready handshakes on both input and output, so it drops into streaming datapaths as the successor to the fixed 128-bit Simon top.
- Core is encryption-only.

---
 rtl/simon_pkg.sv | 55 +++++
 rtl/simon_key_step.sv | 34 +++
 rtl/simon_core_param.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/simon_pkg.sv
// Simon cipher shared definitions: z-sequences, round/z-index lookup,
// and the core FSM state type.
package simon_pkg;

  localparam int ZLEN = 62;

  // z0..z4; bit 61 is the first element of each sequence.
  localparam logic [61:0] Z [5] = '{
    62'b11111010001001010110000111001101111101000100101011000011100110,
    62'b10001110111110010011000010110101000111011111001001100001011010,
    62'b10101111011100000011010010011000101000010001111110010110110011,
    62'b11011011101011000110010111100000010010001010011100110100001111,
    62'b11010001111001101011011000100000010111000011001010010011101111
  };

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Returns 0 for an illegal (n,m) pair; the core refuses to elaborate.
  function automatic int rounds(input int n, input int m);
    case (n * 10 + m)
      164:     return 32;
      243:     return 36;
      244:     return 36;
      323:     return 42;
      324:     return 44;
      482:     return 52;
      483:     return 54;
      642:     return 68;
      643:     return 69;
      644:     return 72;
      default: return 0;
    endcase
  endfunction

  function automatic int zidx(input int n, input int m);
    case (n * 10 + m)
      164:     return 0;
      243:     return 0;
      244:     return 1;
      323:     return 2;
      324:     return 3;
      482:     return 2;
      483:     return 3;
      642:     return 2;
      643:     return 3;
      644:     return 4;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/simon_key_step.sv
// Simon key-schedule step (combinational).
// kreg_i: current key window (kreg_i[0] oldest), z_i: z bit, knew_o: next key word.
module simon_key_step
  import simon_pkg::*;
#(
  parameter int N = 64,
  parameter int M = 2
) (
  input  logic [N-1:0] kreg_i [M],
  input  logic         z_i,
  output logic [N-1:0] knew_o
);

  function automatic logic [N-1:0] rotr(
    input logic [N-1:0] v,
    input int           s
  );
    return (v >> s) | (v << (N - s));
  endfunction

  logic [N-1:0] t0;
  logic [N-1:0] t1;
  logic [N-1:0] t2;

  always_comb begin
    t0 = rotr(kreg_i[M-1], 3);
    t1 = (M == 4) ? (t0 ^ kreg_i[1]) : t0;
    t2 = t1 ^ rotr(t1, 1);
    knew_o = ~kreg_i[0] ^ t2
           ^ {{(N-1){1'b0}}, z_i}
           ^ N'(3);
  end

endmodule

// File: rtl/simon_core_param.sv
// Iterative Simon 2N/MN encryption core, one round per clock.
// in: in_valid/in_ready, pt_i, k_i; out: out_valid/out_ready, ct_o; busy.
module simon_core_param
  import simon_pkg::*;
#(
  parameter int N  = 64,
  parameter int M  = 2,
  parameter int T  = rounds(N, M),
  parameter int ZI = zidx(N, M)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] pt_i,
  input  logic [M*N-1:0] k_i,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] ct_o,
  output logic           busy
);

  if (rounds(N, M) == 0) begin : g_bad
    $error("simon_core_param: illegal N/M pair");
  end

  localparam int RW = 7;

  function automatic logic [N-1:0] rotl(
    input logic [N-1:0] v,
    input int           s
  );
    return (v << s) | (v >> (N - s));
  endfunction

  state_t state_q, state_d;

  logic [N-1:0]   x_q, x_d;
  logic [N-1:0]   y_q, y_d;
  logic [N-1:0]   kreg_q [M];
  logic [N-1:0]   kreg_d [M];
  logic [RW-1:0]  rcnt_q, rcnt_d;
  logic [5:0]     zcnt_q, zcnt_d;
  logic [2*N-1:0] ct_q, ct_d;

  logic [N-1:0] knew;
  logic [N-1:0] fx;
  logic [N-1:0] x_nx;
  logic         zbit;
  logic         last;

  assign zbit = Z[ZI][6'd61 - zcnt_q];
  assign last = (rcnt_q == RW'(T - 1));

  simon_key_step #(
    .N(N),
    .M(M)
  ) u_key (
    .kreg_i(kreg_q),
    .z_i   (zbit),
    .knew_o(knew)
  );

  always_comb begin
    fx   = (rotl(x_q, 1) & rotl(x_q, 8))
         ^ rotl(x_q, 2);
    x_nx = y_q ^ fx ^ kreg_q[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      kreg_q  <= '{default: '0};
      rcnt_q  <= '0;
      zcnt_q  <= '0;
      ct_q    <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      kreg_q  <= kreg_d;
      rcnt_q  <= rcnt_d;
      zcnt_q  <= zcnt_d;
      ct_q    <= ct_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == IDLE): if (in_valid)  state_d = RUN;
      (state_q == RUN):  if (last)      state_d = DONE;
      (state_q == DONE): if (out_ready) state_d = IDLE;
      default:           state_d = IDLE;
    endcase
  end

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    kreg_d = kreg_q;
    rcnt_d = rcnt_q;
    zcnt_d = zcnt_q;
    ct_d   = ct_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d = pt_i[2*N-1:N];
          y_d = pt_i[N-1:0];
          for (int j = 0; j < M; j++)
            kreg_d[j] = k_i[j*N +: N];
          rcnt_d = '0;
          zcnt_d = '0;
        end
      end
      RUN: begin
        x_d = x_nx;
        y_d = x_q;
        for (int j = 0; j < M - 1; j++)
          kreg_d[j] = kreg_q[j+1];
        kreg_d[M-1] = knew;
        rcnt_d = rcnt_q + 1'b1;
        // z sequences have period 62
        zcnt_d = (zcnt_q == 6'd61) ? 6'd0 : zcnt_q + 6'd1;
        if (last) ct_d = {x_nx, x_q};
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    ct_o      = ct_q;
  end

endmodule
